link_spi_controller: RTL
========================

# link_spi_controller

Command sequencer sitting directly behind `LinkSpi`. It consumes the decoded SPI packet header and payload, filters packets by device address, and dispatches them by command code:
- SEND_DATA payload goes into the Mil transmit FIFO.
- RECEIVE_STS and RECEIVE_DATA replies are built and served to `LinkSpi` over the pop handshake, with the reply output enabled.
- RESET produces a one-cycle system reset request.

## Interface
Parameters:
- `ADDR_W`, 8, device/packet address width
- `WORD_W`, 16, data word width
- `STS_WORDS`, 10, number of words in a status reply (extra requested words return 0)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `devAddr`  in  ADDR_W  own device address (static)
- `inPacketStart`  in  1  one-cycle pulse, header valid
- `inPacketEnd`  in  1  one-cycle pulse, packet finished (after checksum)
- `inPacketErr`  in  1  qualifies `inPacketEnd`: checksum mismatch
- `inAddr`  in  ADDR_W  packet address, valid at `inPacketStart`
- `inCmdCode`  in  TccCommand  command, valid at `inPacketStart`
- `spiWordReq`  in  1  payload word strobe from `LinkSpi` push side
- `spiWordData`  in  WORD_W  payload word
- `txPush`  out  1  push strobe to Mil transmit FIFO
- `txData`  out  WORD_W  word to transmit FIFO
- `txFull`  in  1  transmit FIFO full
- `rxPop`  out  1  pop strobe to Mil receive FIFO
- `rxData`  in  WORD_W  receive FIFO head, valid one cycle after `rxPop`
- `rxEmpty`  in  1  receive FIFO empty
- `rxUsed`, `txUsed`  in  WORD_W  FIFO fill counts
- `popReq`  in  1  reply word request from `LinkSpi`
- `popData`  out  WORD_W  reply word
- `popDone`  out  1  reply word valid pulse
- `outEnable`  out  1  reply transmission enable to `LinkSpi`
- `outAddr`  out  ADDR_W  reply address, driven from `devAddr`
- `sysRstReq`  out  1  one-cycle reset request
- `errCount`  out  8  saturating error counter

## Operation
- States: IDLE, DROP, SEND, STATUS, RECV, RST.
- IDLE on `inPacketStart`:
  - `inAddr != devAddr` → DROP.
  - Otherwise dispatch on `inCmdCode`: SEND_DATA → SEND; RECEIVE_STS → STATUS; RECEIVE_DATA → RECV; RESET → RST; UNKNOWN or other → DROP with `errCount`+1.
- SEND: each `spiWordReq` → `txPush`=1 and `txData`=`spiWordData` next cycle. If `txFull`, the word is discarded with `errCount`+1.
- STATUS: reply word index k starts at 0 at state entry and increments per `popReq`.
  - Word 0 = `rxUsed`.
  - Word 1 = `txUsed`.
  - Word 2 = {8'h00, `errCount`}.
  - Words 3..STS_WORDS-1 = 0.
  - k ≥ STS_WORDS → 0.
- RECV: each `popReq` with `!rxEmpty` asserts `rxPop`, and `rxData` is returned. With `rxEmpty`, 16'h0000 is returned and no pop is issued.
- RST: `sysRstReq`=1 for exactly one cycle, issued at `inPacketEnd` only when `inPacketErr`=0. Return to IDLE.
- Any state on `inPacketEnd` → IDLE. `inPacketErr`=1 → `errCount`+1 (saturates at 8'hFF).
- `inPacketStart` in a non-IDLE state: the current packet is abandoned, `errCount`+1, and the new packet is dispatched as from IDLE.
- `outEnable`=1 only in STATUS or RECV.

## Timing
- Reset values: state IDLE, all strobes 0, `popData`=0, `txData`=0, `errCount`=0, `outEnable`=0.
- `outAddr`=`devAddr` combinationally.
- Dispatch latency: state valid the cycle after `inPacketStart`. `outEnable` rises that same cycle.
- `txPush` latency: 1 cycle after `spiWordReq`.
- STATUS reply latency: `popDone`/`popData` 1 cycle after `popReq`.
- RECV reply latency: `rxPop` in the cycle after `popReq`, then `popDone`/`popData` 2 cycles after `popReq`. `LinkSpi` must not issue a new `popReq` before `popDone`; a `popReq` arriving while a reply is pending is ignored.
- `sysRstReq` is asserted in the cycle after a good `inPacketEnd` in RST.
- `errCount` increments are merged: several error sources in one cycle count as +1.
- `rst` mid-packet: immediate return to IDLE. Remaining payload is ignored until the next `inPacketStart`.

## Structure
- `TccCommand` enum and the state enum belong in the `ServiceProtocol` package. Add `STS_WORDS` as a package constant.
- Single module, no sub-modules. The status word mux is an internal function.

## Test plan
- devAddr=AB; header AB/SEND_DATA; words FFA1, 0001, 0002, AB45; good end → four `txPush` carrying those values in order, 1 cycle after each `spiWordReq`; `errCount`=0.
- Header AB/RECEIVE_STS; rxUsed=3, txUsed=4; 10 `popReq` → `popData` sequence 0003, 0004, 0000, then seven 0000; `outEnable` high from start+1 until end.
- RX FIFO holding 1111, 2222; RECEIVE_DATA with 4 `popReq` → 1111, 2222, 0000, 0000; exactly 2 `rxPop`.
- Header 01/RESET with devAddr=AB → no `sysRstReq`, state DROP. Header AB/RESET with good end → one `sysRstReq` pulse. Header AB/RESET with `inPacketErr` → no pulse, `errCount`=1.
- SEND_DATA with `txFull`=1 for 2 words → no `txPush` for those words, `errCount`+2.
- `rst` pulse mid SEND_DATA → IDLE, no further `txPush` for that packet's remaining words.

Source files
------------

// File: rtl/service_protocol_pkg.sv
// Shared command/state encodings and reply sizing for the LinkSpi command sequencer.
package service_protocol_pkg;

    localparam int unsigned CMD_W     = 8;
    localparam int unsigned STS_WORDS = 10;

    typedef enum logic [CMD_W-1:0] {
        CMD_UNKNOWN      = 8'h00,
        CMD_SEND_DATA    = 8'h01,
        CMD_RECEIVE_STS  = 8'h02,
        CMD_RECEIVE_DATA = 8'h03,
        CMD_RESET        = 8'h04
    } tcc_command_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DROP,
        ST_SEND,
        ST_STATUS,
        ST_RECV,
        ST_RST
    } state_e;

endpackage

// File: rtl/link_spi_controller.sv
// Command sequencer behind LinkSpi: address filter, command dispatch, TX push,
// status/receive reply serving and system reset requests.
module link_spi_controller
    import service_protocol_pkg::tcc_command_e, service_protocol_pkg::state_e,
           service_protocol_pkg::CMD_SEND_DATA, service_protocol_pkg::CMD_RECEIVE_STS,
           service_protocol_pkg::CMD_RECEIVE_DATA, service_protocol_pkg::CMD_RESET,
           service_protocol_pkg::ST_IDLE, service_protocol_pkg::ST_DROP,
           service_protocol_pkg::ST_SEND, service_protocol_pkg::ST_STATUS,
           service_protocol_pkg::ST_RECV, service_protocol_pkg::ST_RST;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned STS_WORDS = service_protocol_pkg::STS_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] devAddr,
    input  logic              inPacketStart,
    input  logic              inPacketEnd,
    input  logic              inPacketErr,
    input  logic [ADDR_W-1:0] inAddr,
    input  tcc_command_e      inCmdCode,
    input  logic              spiWordReq,
    input  logic [WORD_W-1:0] spiWordData,
    output logic              txPush,
    output logic [WORD_W-1:0] txData,
    input  logic              txFull,
    output logic              rxPop,
    input  logic [WORD_W-1:0] rxData,
    input  logic              rxEmpty,
    input  logic [WORD_W-1:0] rxUsed,
    input  logic [WORD_W-1:0] txUsed,
    input  logic              popReq,
    output logic [WORD_W-1:0] popData,
    output logic              popDone,
    output logic              outEnable,
    output logic [ADDR_W-1:0] outAddr,
    output logic              sysRstReq,
    output logic [7:0]        errCount
);

    state_e            state_q, state_n;
    logic              tx_push_n, rx_pop_n, pop_done_n, sys_rst_n, out_en_n;
    logic [WORD_W-1:0] tx_data_n, pop_data_q, pop_data_n;
    logic [WORD_W-1:0] sts_idx_q, sts_idx_n;
    logic              recv_s1_q, recv_s1_n, recv_fwd_q, recv_fwd_n;
    logic [7:0]        err_n;
    logic              err_inc;

    // Status reply word selection by index
    function automatic logic [WORD_W-1:0] status_word(
        input logic [WORD_W-1:0] idx,
        input logic [WORD_W-1:0] rx_used,
        input logic [WORD_W-1:0] tx_used,
        input logic [7:0]        errs
    );
        logic [WORD_W-1:0] w;
        w = '0;
        if (idx < WORD_W'(STS_WORDS)) begin
            if (idx == WORD_W'(0))      w = rx_used;
            else if (idx == WORD_W'(1)) w = tx_used;
            else if (idx == WORD_W'(2)) w = WORD_W'(errs);
        end
        return w;
    endfunction

    // Receive replies forward the FIFO head straight out in the popDone cycle
    assign popData = recv_fwd_q ? rxData : pop_data_q;
    assign outAddr = devAddr;

    always_comb begin
        state_n    = state_q;
        tx_push_n  = 1'b0;
        tx_data_n  = txData;
        rx_pop_n   = 1'b0;
        pop_done_n = 1'b0;
        pop_data_n = recv_fwd_q ? rxData : pop_data_q;
        sys_rst_n  = 1'b0;
        sts_idx_n  = sts_idx_q;
        recv_s1_n  = 1'b0;
        recv_fwd_n = 1'b0;
        err_inc    = 1'b0;

        case (state_q)
            ST_SEND: begin
                if (spiWordReq) begin
                    if (txFull) begin
                        err_inc = 1'b1;
                    end else begin
                        tx_push_n = 1'b1;
                        tx_data_n = spiWordData;
                    end
                end
            end
            ST_STATUS: begin
                if (popReq) begin
                    pop_done_n = 1'b1;
                    pop_data_n = status_word(sts_idx_q, rxUsed, txUsed, errCount);
                    if (sts_idx_q < WORD_W'(STS_WORDS)) sts_idx_n = sts_idx_q + WORD_W'(1);
                end
            end
            ST_RECV: begin
                if (popReq && !recv_s1_q) begin
                    recv_s1_n = 1'b1;
                    rx_pop_n  = !rxEmpty;
                end
            end
            ST_RST: begin
                if (inPacketEnd && !inPacketErr) sys_rst_n = 1'b1;
            end
            default: ;
        endcase

        // Second stage of a receive reply: data if popped, zero otherwise
        if (recv_s1_q) begin
            pop_done_n = 1'b1;
            if (rxPop) recv_fwd_n = 1'b1;
            else       pop_data_n = '0;
        end

        if (inPacketEnd) begin
            state_n = ST_IDLE;
            if (inPacketErr) err_inc = 1'b1;
        end

        if (inPacketStart) begin
            if (state_q != ST_IDLE) err_inc = 1'b1;
            sts_idx_n = '0;
            if (inAddr != devAddr) begin
                state_n = ST_DROP;
            end else begin
                case (inCmdCode)
                    CMD_SEND_DATA:    state_n = ST_SEND;
                    CMD_RECEIVE_STS:  state_n = ST_STATUS;
                    CMD_RECEIVE_DATA: state_n = ST_RECV;
                    CMD_RESET:        state_n = ST_RST;
                    default: begin
                        state_n = ST_DROP;
                        err_inc = 1'b1;
                    end
                endcase
            end
        end

        err_n    = (err_inc && errCount != 8'hFF) ? errCount + 8'd1 : errCount;
        out_en_n = (state_n == ST_STATUS) || (state_n == ST_RECV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            txPush     <= 1'b0;
            txData     <= '0;
            rxPop      <= 1'b0;
            popDone    <= 1'b0;
            pop_data_q <= '0;
            sysRstReq  <= 1'b0;
            outEnable  <= 1'b0;
            errCount   <= 8'h00;
            sts_idx_q  <= '0;
            recv_s1_q  <= 1'b0;
            recv_fwd_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            txPush     <= tx_push_n;
            txData     <= tx_data_n;
            rxPop      <= rx_pop_n;
            popDone    <= pop_done_n;
            pop_data_q <= pop_data_n;
            sysRstReq  <= sys_rst_n;
            outEnable  <= out_en_n;
            errCount   <= err_n;
            sts_idx_q  <= sts_idx_n;
            recv_s1_q  <= recv_s1_n;
            recv_fwd_q <= recv_fwd_n;
        end
    end

endmodule
